ctrl_pipeline: RTL and testbench
================================

Name: ctrl_pipeline

Overview:
- Consumer end of the decoded-control interface. It takes the per-instruction control bundle produced in ID and carries it through the ID/EX, EX/MEM and MEM/WB stage registers.
- It computes the write-destination register for each instruction.
- It detects load-use hazards and stalls ID/IF.
- It produces operand-forwarding selects for the EX stage.
- It applies control-flow flushes and counts retired instructions.

Parameters:
- RA_W, 5, register-address width.
- ALU_W, 5, alu_control width.
- BCU_W, 4, bcu_control width.
- CNT_W, 32, retired-instruction counter width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_reg_write, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_dst, id_branch, id_jal, id_load_upper  in  1 each  decoded controls
- id_jump  in  2  decoded jump type
- id_alu_control  in  ALU_W  decoded ALU op
- id_bcu_control  in  BCU_W  decoded branch condition
- id_rs, id_rt, id_rd  in  RA_W  instruction register fields
- flush  in  1  control transfer resolved this cycle; kill the instruction in ID
- stall_id  out  1  combinational; hold PC and the IF/ID register
- ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_branch, ex_jal, ex_load_upper  out  1 each  ID/EX controls
- ex_jump  out  2  ID/EX jump type
- ex_alu_control  out  ALU_W  ID/EX ALU op
- ex_bcu_control  out  BCU_W  ID/EX branch condition
- ex_dest  out  RA_W  ID/EX destination register
- fwd_a, fwd_b  out  2  EX operand source: 00 register file, 10 EX/MEM, 01 MEM/WB
- mem_reg_write, mem_mem_to_reg, mem_mem_write  out  1  EX/MEM controls
- mem_dest  out  RA_W  EX/MEM destination register
- wb_reg_write, wb_mem_to_reg  out  1  MEM/WB controls
- wb_dest  out  RA_W  MEM/WB destination register
- retired  out  CNT_W  count of valid instructions leaving WB

Behaviour:
- Reset (async, rst=1): every stage register, every valid bit, every registered output and retired go to 0 immediately.
- Reset is held until the first rising clk after rst deasserts; any instruction in flight at reset is discarded.
- Destination computed in ID:
  - id_jal=1 -> 5'd31 (jal has priority over reg_dst)
  - else id_reg_dst=1 -> id_rd
  - else -> id_rt
- A bubble is valid=0 with every control output 0, dest 0, alu_control 0 and bcu_control 0.
- Stage advance on every rising clk (no external stall input):
  - MEM/WB <= EX/MEM.
  - EX/MEM <= ID/EX.
  - ID/EX <= bubble if stall_id or flush or !id_valid; otherwise the ID bundle.
- Load-use hazard (combinational): stall_id = id_valid & ex_valid & ex_mem_to_reg & (ex_dest != 0) & (ex_dest == id_rs | ex_dest == id_rt).
  - stall_id ignores flush.
  - Flush and stall together -> ID/EX gets a bubble; the fetch unit gives flush priority for PC.
- Stall length: exactly one bubble per load-use pair. The next cycle the load is in MEM and forwarding covers the dependency.
- Forwarding (combinational, from registered state), for operand a with src = ex_rs (rs latched into ID/EX):
  - 10 if mem_valid & mem_reg_write & mem_dest != 0 & mem_dest == src
  - else 01 if wb_valid & wb_reg_write & wb_dest != 0 & wb_dest == src
  - else 00
  - EX/MEM has priority over MEM/WB.
  - fwd_b is identical using ex_rt.
- Register 0 never forwards and never causes a stall.
- Retired counter: retired increments by 1 on each clk where MEM/WB valid=1. It wraps at 2^CNT_W-1 -> 0.
- All stage-register outputs have 1-cycle latency per stage. An ID bundle accepted at edge N appears on ex_* after N, on mem_* after N+1 and on wb_* after N+2. retired counts it at edge N+3.

Test Plan:
- Reset: drive a valid add bundle, assert rst mid-cycle -> all outputs 0 with no clock edge; after release plus 3 edges with id_valid=0, retired=0.
- Destination: R-type with rd=9, rt=4, reg_dst=1 -> ex_dest=9. lw with rt=4 -> 4. jal with reg_dst=1 -> 31. Each propagates to wb_dest two edges later.
- Load-use: lw dest 8, then add with rs=8 -> stall_id=1 for exactly 1 cycle, ex_* bubble, then fwd_a=01 for the add. Same sequence with rs=0 -> stall_id stays 0.
- Forwarding priority: add dest 5, add dest 5, then sub with rs=5, rt=5 -> fwd_a=fwd_b=10. With one independent instruction between -> 01.
- Flush: valid bundle in ID with flush=1 -> ex_reg_write=ex_mem_write=ex_branch=0 next cycle. retired unchanged 3 edges later.
- Counter: 10 valid back-to-back instructions, no hazards -> retired=10 after 13 edges. Preload-free wrap check with CNT_W=4: 17 instructions -> retired=1.

Source files
------------

// File: rtl/ctrl_pipeline.sv
// Control-side pipeline: carries decoded controls through ID/EX, EX/MEM and MEM/WB,
// detects load-use hazards, generates EX forwarding selects and counts retired instructions.
module ctrl_pipeline #(
    parameter int RA_W  = 5,
    parameter int ALU_W = 5,
    parameter int BCU_W = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_reg_write,
    input  logic             id_mem_to_reg,
    input  logic             id_mem_write,
    input  logic             id_alu_src,
    input  logic             id_reg_dst,
    input  logic             id_branch,
    input  logic             id_jal,
    input  logic             id_load_upper,
    input  logic [1:0]       id_jump,
    input  logic [ALU_W-1:0] id_alu_control,
    input  logic [BCU_W-1:0] id_bcu_control,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             flush,
    output logic             stall_id,
    output logic             ex_reg_write,
    output logic             ex_mem_to_reg,
    output logic             ex_mem_write,
    output logic             ex_alu_src,
    output logic             ex_branch,
    output logic             ex_jal,
    output logic             ex_load_upper,
    output logic [1:0]       ex_jump,
    output logic [ALU_W-1:0] ex_alu_control,
    output logic [BCU_W-1:0] ex_bcu_control,
    output logic [RA_W-1:0]  ex_dest,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_reg_write,
    output logic             mem_mem_to_reg,
    output logic             mem_mem_write,
    output logic [RA_W-1:0]  mem_dest,
    output logic             wb_reg_write,
    output logic             wb_mem_to_reg,
    output logic [RA_W-1:0]  wb_dest,
    output logic [CNT_W-1:0] retired
);

    typedef struct packed {
        logic             valid;
        logic             reg_write;
        logic             mem_to_reg;
        logic             mem_write;
        logic             alu_src;
        logic             branch;
        logic             jal;
        logic             load_upper;
        logic [1:0]       jump;
        logic [ALU_W-1:0] alu_control;
        logic [BCU_W-1:0] bcu_control;
        logic [RA_W-1:0]  dest;
        logic [RA_W-1:0]  rs;
        logic [RA_W-1:0]  rt;
    } idex_t;

    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic            mem_to_reg;
        logic            mem_write;
        logic [RA_W-1:0] dest;
    } exmem_t;

    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic            mem_to_reg;
        logic [RA_W-1:0] dest;
    } memwb_t;

    idex_t            idex_q, idex_d;
    exmem_t           exmem_q, exmem_d;
    memwb_t           memwb_q, memwb_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [RA_W-1:0]  id_dest;
    logic [1:0][1:0]  fwd_sel;

    always_comb begin
        id_dest = id_rt;
        if (id_jal)
            id_dest = RA_W'(31);
        else if (id_reg_dst)
            id_dest = id_rd;
    end

    // Register 0 is hardwired, so a load targeting it can never create a dependency.
    assign stall_id = id_valid & idex_q.valid & idex_q.mem_to_reg & (idex_q.dest != '0)
                    & ((idex_q.dest == id_rs) | (idex_q.dest == id_rt));

    always_comb begin
        idex_d = '0;
        if (id_valid && !stall_id && !flush) begin
            idex_d.valid       = 1'b1;
            idex_d.reg_write   = id_reg_write;
            idex_d.mem_to_reg  = id_mem_to_reg;
            idex_d.mem_write   = id_mem_write;
            idex_d.alu_src     = id_alu_src;
            idex_d.branch      = id_branch;
            idex_d.jal         = id_jal;
            idex_d.load_upper  = id_load_upper;
            idex_d.jump        = id_jump;
            idex_d.alu_control = id_alu_control;
            idex_d.bcu_control = id_bcu_control;
            idex_d.dest        = id_dest;
            idex_d.rs          = id_rs;
            idex_d.rt          = id_rt;
        end
    end

    always_comb begin
        exmem_d            = '0;
        exmem_d.valid      = idex_q.valid;
        exmem_d.reg_write  = idex_q.reg_write;
        exmem_d.mem_to_reg = idex_q.mem_to_reg;
        exmem_d.mem_write  = idex_q.mem_write;
        exmem_d.dest       = idex_q.dest;

        memwb_d            = '0;
        memwb_d.valid      = exmem_q.valid;
        memwb_d.reg_write  = exmem_q.reg_write;
        memwb_d.mem_to_reg = exmem_q.mem_to_reg;
        memwb_d.dest       = exmem_q.dest;

        retired_d = retired_q + CNT_W'(memwb_q.valid);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_q    <= '0;
            exmem_q   <= '0;
            memwb_q   <= '0;
            retired_q <= '0;
        end else begin
            idex_q    <= idex_d;
            exmem_q   <= exmem_d;
            memwb_q   <= memwb_d;
            retired_q <= retired_d;
        end
    end

    // Operand 0 compares against rs, operand 1 against rt; the younger EX/MEM result wins.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic [RA_W-1:0] src;
            logic            hit_mem, hit_wb;
            assign src     = (gi == 0) ? idex_q.rs : idex_q.rt;
            assign hit_mem = exmem_q.valid & exmem_q.reg_write & (exmem_q.dest != '0) & (exmem_q.dest == src);
            assign hit_wb  = memwb_q.valid & memwb_q.reg_write & (memwb_q.dest != '0) & (memwb_q.dest == src);
            assign fwd_sel[gi] = hit_mem ? 2'b10 : (hit_wb ? 2'b01 : 2'b00);
        end
    endgenerate

    assign fwd_a = fwd_sel[0];
    assign fwd_b = fwd_sel[1];

    assign ex_reg_write   = idex_q.reg_write;
    assign ex_mem_to_reg  = idex_q.mem_to_reg;
    assign ex_mem_write   = idex_q.mem_write;
    assign ex_alu_src     = idex_q.alu_src;
    assign ex_branch      = idex_q.branch;
    assign ex_jal         = idex_q.jal;
    assign ex_load_upper  = idex_q.load_upper;
    assign ex_jump        = idex_q.jump;
    assign ex_alu_control = idex_q.alu_control;
    assign ex_bcu_control = idex_q.bcu_control;
    assign ex_dest        = idex_q.dest;

    assign mem_reg_write  = exmem_q.reg_write;
    assign mem_mem_to_reg = exmem_q.mem_to_reg;
    assign mem_mem_write  = exmem_q.mem_write;
    assign mem_dest       = exmem_q.dest;

    assign wb_reg_write   = memwb_q.reg_write;
    assign wb_mem_to_reg  = memwb_q.mem_to_reg;
    assign wb_dest        = memwb_q.dest;

    assign retired        = retired_q;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed bench for ctrl_pipeline: destination select, load-use stall, forwarding,
// flush, async reset and retired-counter wrap (counter built 4 bits wide).
module tb_ctrl_pipeline;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_reg_write, id_mem_to_reg, id_mem_write, id_alu_src;
    logic       id_reg_dst, id_branch, id_jal, id_load_upper;
    logic [1:0] id_jump;
    logic [4:0] id_alu_control;
    logic [3:0] id_bcu_control;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       flush;
    logic       stall_id;
    logic       ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_branch, ex_jal, ex_load_upper;
    logic [1:0] ex_jump;
    logic [4:0] ex_alu_control;
    logic [3:0] ex_bcu_control;
    logic [4:0] ex_dest;
    logic [1:0] fwd_a, fwd_b;
    logic       mem_reg_write, mem_mem_to_reg, mem_mem_write;
    logic [4:0] mem_dest;
    logic       wb_reg_write, wb_mem_to_reg;
    logic [4:0] wb_dest;
    logic [3:0] retired;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ctrl_pipeline #(.RA_W(5), .ALU_W(5), .BCU_W(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
        .id_mem_write(id_mem_write), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_branch(id_branch), .id_jal(id_jal), .id_load_upper(id_load_upper),
        .id_jump(id_jump), .id_alu_control(id_alu_control), .id_bcu_control(id_bcu_control),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
        .stall_id(stall_id),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write),
        .ex_alu_src(ex_alu_src), .ex_branch(ex_branch), .ex_jal(ex_jal), .ex_load_upper(ex_load_upper),
        .ex_jump(ex_jump), .ex_alu_control(ex_alu_control), .ex_bcu_control(ex_bcu_control),
        .ex_dest(ex_dest), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg), .mem_mem_write(mem_mem_write),
        .mem_dest(mem_dest), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_dest(wb_dest), .retired(retired)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // v rw mtr mw rdst jal br rs rt rd; other controls cleared
    task automatic drive(input logic v, input logic rw, input logic mtr, input logic mw,
                         input logic rdst, input logic jal, input logic br,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        id_valid = v;      id_reg_write = rw;  id_mem_to_reg = mtr; id_mem_write = mw;
        id_reg_dst = rdst; id_jal = jal;       id_branch = br;
        id_rs = rs;        id_rt = rt;         id_rd = rd;
        id_alu_src = 1'b0; id_load_upper = 1'b0; id_jump = 2'b00;
        id_alu_control = 5'd0; id_bcu_control = 4'd0;
    endtask

    task automatic nop();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic do_reset();
        nop();
        flush = 1'b0;
        rst   = 1'b1;
        tick();
        rst   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        do_reset();

        // Asynchronous reset with instructions in flight
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd9);
        repeat (4) tick();
        check("pre_rst_retired", 32'(retired), 32'd1);
        check("pre_rst_ex_dest", 32'(ex_dest), 32'd9);
        #2 rst = 1'b1;
        #1;
        check("rst_ex_reg_write", 32'(ex_reg_write), 32'd0);
        check("rst_ex_dest", 32'(ex_dest), 32'd0);
        check("rst_mem_reg_write", 32'(mem_reg_write), 32'd0);
        check("rst_wb_dest", 32'(wb_dest), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        nop();
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("post_rst_retired", 32'(retired), 32'd0);

        // Destination selection and propagation
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 5'd4, 5'd9);
        tick();
        check("dest_rtype", 32'(ex_dest), 32'd9);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd4, 5'd0);
        tick();
        check("dest_lw", 32'(ex_dest), 32'd4);
        check("dest_rtype_mem", 32'(mem_dest), 32'd9);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd7);
        id_alu_control = 5'd13; id_bcu_control = 4'd6; id_jump = 2'b10;
        id_alu_src = 1'b1; id_load_upper = 1'b1;
        tick();
        check("dest_jal", 32'(ex_dest), 32'd31);
        check("jal_ex_jal", 32'(ex_jal), 32'd1);
        check("jal_alu_ctl", 32'(ex_alu_control), 32'd13);
        check("jal_bcu_ctl", 32'(ex_bcu_control), 32'd6);
        check("jal_jump", 32'(ex_jump), 32'd2);
        check("jal_alu_src", 32'(ex_alu_src), 32'd1);
        check("jal_load_upper", 32'(ex_load_upper), 32'd1);
        check("dest_rtype_wb", 32'(wb_dest), 32'd9);
        check("lw_mem_to_reg_mem", 32'(mem_mem_to_reg), 32'd1);
        nop();
        tick();
        check("dest_lw_wb", 32'(wb_dest), 32'd4);
        check("lw_wb_mem_to_reg", 32'(wb_mem_to_reg), 32'd1);
        check("nop_ex_bubble", 32'(ex_reg_write), 32'd0);
        tick();
        check("dest_jal_wb", 32'(wb_dest), 32'd31);

        // Load-use stall for one cycle, then MEM/WB forwarding
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 5'd8, 5'd0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd8, 5'd3, 5'd10);
        #1;
        check("lu_stall", 32'(stall_id), 32'd1);
        tick();
        check("lu_bubble_rw", 32'(ex_reg_write), 32'd0);
        check("lu_bubble_dest", 32'(ex_dest), 32'd0);
        check("lu_load_mem", 32'(mem_dest), 32'd8);
        check("lu_stall_gone", 32'(stall_id), 32'd0);
        tick();
        check("lu_add_dest", 32'(ex_dest), 32'd10);
        check("lu_fwd_a", 32'(fwd_a), 32'd1);
        check("lu_fwd_b", 32'(fwd_b), 32'd0);
        nop();

        // Load into r0 never stalls
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 5'd0, 5'd0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd3, 5'd10);
        #1;
        check("r0_no_stall", 32'(stall_id), 32'd0);
        tick();
        check("r0_add_dest", 32'(ex_dest), 32'd10);
        check("r0_fwd_a", 32'(fwd_a), 32'd0);
        nop();

        // EX/MEM wins over MEM/WB
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd5);
        tick();
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd5, 5'd5, 5'd6);
        tick();
        check("fwd_pri_a", 32'(fwd_a), 32'd2);
        check("fwd_pri_b", 32'(fwd_b), 32'd2);
        nop();

        // One independent instruction between -> MEM/WB
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd5);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd7);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd5, 5'd5, 5'd6);
        tick();
        check("fwd_wb_a", 32'(fwd_a), 32'd1);
        check("fwd_wb_b", 32'(fwd_b), 32'd1);
        nop();

        // Flush kills the ID instruction
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        nop();
        check("flush_rw", 32'(ex_reg_write), 32'd0);
        check("flush_mw", 32'(ex_mem_write), 32'd0);
        check("flush_br", 32'(ex_branch), 32'd0);
        repeat (3) tick();
        check("flush_retired", 32'(retired), 32'd0);

        // Ten back-to-back instructions
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd9);
            tick();
        end
        nop();
        tick();
        tick();
        check("cnt_12_edges", 32'(retired), 32'd9);
        tick();
        check("cnt_13_edges", 32'(retired), 32'd10);

        // 17 instructions wrap a 4-bit counter to 1
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0);
            tick();
        end
        nop();
        repeat (3) tick();
        check("cnt_wrap", 32'(retired), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
